// File: rtl/rvh_l1d_ld_wb_arb.sv
// ---------------------------------------------------------------------------
// rvh_l1d_ld_wb_arb
// Arbitrates the single L1D load writeback port between pipeline load hits
// (which cannot be back-pressured) and MLFB refill responses (buffered in a
// small FIFO). Hits always win the port. A refill that keeps losing for
// STARVE_LIMIT cycles forces a DRAIN phase. In that phase the load issue
// stage is stalled until the refill buffer empties.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   flush_i                    drops all buffered and offered refills
//   hit_*                      load hit response (valid, rob tag, prd, data)
//   refill_*                   refill response with ready/valid handshake
//   l1d_rob_wb_*               ROB writeback (valid, rob tag)
//   l1d_int_prf_wb_*           integer PRF writeback (valid, tag, data,
//                              from_mlfb marks a refill-sourced writeback)
//   hit_stall_o                stall request to the load issue stage
// ---------------------------------------------------------------------------
module rvh_l1d_ld_wb_arb #(
    parameter int REFILL_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT      = 8,
    parameter int ROB_TAG_WIDTH     = 7,
    parameter int PREG_TAG_WIDTH    = 7,
    parameter int XLEN              = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,

    input  logic                      hit_vld_i,
    input  logic [ROB_TAG_WIDTH-1:0]  hit_rob_tag_i,
    input  logic [PREG_TAG_WIDTH-1:0] hit_prd_i,
    input  logic [XLEN-1:0]           hit_data_i,

    input  logic                      refill_vld_i,
    output logic                      refill_rdy_o,
    input  logic [ROB_TAG_WIDTH-1:0]  refill_rob_tag_i,
    input  logic [PREG_TAG_WIDTH-1:0] refill_prd_i,
    input  logic [XLEN-1:0]           refill_data_i,

    output logic                      l1d_rob_wb_vld_o,
    output logic [ROB_TAG_WIDTH-1:0]  l1d_rob_wb_rob_tag_o,
    output logic                      l1d_int_prf_wb_vld_o,
    output logic [PREG_TAG_WIDTH-1:0] l1d_int_prf_wb_tag_o,
    output logic [XLEN-1:0]           l1d_int_prf_wb_data_o,
    output logic                      l1d_int_prf_wb_vld_from_mlfb_o,

    output logic                      hit_stall_o
);

    localparam int PTR_W = $clog2(REFILL_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {HIT_PRI, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [STV_W-1:0]   starve_reg, starve_next;

    // Small buffer read asynchronously so the head is available in the same
    // cycle it is popped. Contents are never reset; count/pointers qualify them.
    logic [ROB_TAG_WIDTH-1:0]  rob_tag_mem [REFILL_FIFO_DEPTH];
    logic [PREG_TAG_WIDTH-1:0] prd_mem     [REFILL_FIFO_DEPTH];
    logic [XLEN-1:0]           data_mem    [REFILL_FIFO_DEPTH];

    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_empty   = (count_reg == '0);
    assign refill_rdy_o = ~rst & ~flush_i & (count_reg < CNT_W'(REFILL_FIFO_DEPTH));
    assign push         = refill_vld_i & refill_rdy_o;
    // A buffered refill only gets the port when no hit claims it; a flush
    // discards the buffer so its head is not written back either.
    assign pop          = ~rst & ~flush_i & ~hit_vld_i & ~fifo_empty;

    // Depends only on registered state so it cannot form a loop with issue.
    assign hit_stall_o  = (state_reg == DRAIN) |
                          (count_reg >= CNT_W'(REFILL_FIFO_DEPTH - 2));

    always_ff @(posedge clk) begin
        if (push) begin
            rob_tag_mem[wr_ptr_reg] <= refill_rob_tag_i;
            prd_mem[wr_ptr_reg]     <= refill_prd_i;
            data_mem[wr_ptr_reg]    <= refill_data_i;
        end
    end

    // Writeback mux: hit has zero-latency priority, otherwise FIFO head.
    always_comb begin
        l1d_rob_wb_vld_o               = 1'b0;
        l1d_rob_wb_rob_tag_o           = '0;
        l1d_int_prf_wb_vld_o           = 1'b0;
        l1d_int_prf_wb_tag_o           = '0;
        l1d_int_prf_wb_data_o          = '0;
        l1d_int_prf_wb_vld_from_mlfb_o = 1'b0;
        if (!rst) begin
            if (hit_vld_i) begin
                l1d_rob_wb_vld_o      = 1'b1;
                l1d_rob_wb_rob_tag_o  = hit_rob_tag_i;
                l1d_int_prf_wb_vld_o  = 1'b1;
                l1d_int_prf_wb_tag_o  = hit_prd_i;
                l1d_int_prf_wb_data_o = hit_data_i;
            end else if (pop) begin
                l1d_rob_wb_vld_o               = 1'b1;
                l1d_rob_wb_rob_tag_o           = rob_tag_mem[rd_ptr_reg];
                l1d_int_prf_wb_vld_o           = 1'b1;
                l1d_int_prf_wb_tag_o           = prd_mem[rd_ptr_reg];
                l1d_int_prf_wb_data_o          = data_mem[rd_ptr_reg];
                l1d_int_prf_wb_vld_from_mlfb_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

        case (state_reg)
            HIT_PRI: begin
                if (fifo_empty || pop) begin
                    starve_next = '0;
                end else if (hit_vld_i) begin
                    // The increment that would reach the limit moves to DRAIN
                    // and leaves the counter cleared.
                    if (starve_reg == STV_W'(STARVE_LIMIT - 1)) begin
                        state_next  = DRAIN;
                        starve_next = '0;
                    end else begin
                        starve_next = starve_reg + STV_W'(1);
                    end
                end
            end
            DRAIN: begin
                starve_next = '0;
                if (count_next == '0) begin
                    state_next = HIT_PRI;
                end
            end
            default: begin
                state_next  = HIT_PRI;
                starve_next = '0;
            end
        endcase

        if (flush_i) begin
            state_next  = HIT_PRI;
            starve_next = '0;
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= HIT_PRI;
            starve_reg <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

endmodule

// File: doc/rvh_l1d_ld_wb_arb.md
RVH_L1D_LD_WB_ARB -- requirements
Module: rvh_l1d_ld_wb_arb

Interface
REQ-001 SHALL have parameter REFILL_FIFO_DEPTH, default 4, power of two >= 4: refill response buffer entries.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive cycles a buffered refill may lose before forced drain.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: flush_i  in  1  pipeline flush.
REQ-005 SHALL have hit inputs: hit_vld_i  in  1; hit_rob_tag_i  in  ROB_TAG_WIDTH; hit_prd_i  in  PREG_TAG_WIDTH; hit_data_i  in  XLEN. These are load hit responses that cannot be back-pressured.
REQ-006 SHALL have refill inputs: refill_vld_i  in  1; refill_rdy_o  out  1; refill_rob_tag_i  in  ROB_TAG_WIDTH; refill_prd_i  in  PREG_TAG_WIDTH; refill_data_i  in  XLEN. These are MLFB refill load responses.
REQ-007 SHALL have writeback outputs: l1d_rob_wb_vld_o  out  1; l1d_rob_wb_rob_tag_o  out  ROB_TAG_WIDTH; l1d_int_prf_wb_vld_o  out  1; l1d_int_prf_wb_tag_o  out  PREG_TAG_WIDTH; l1d_int_prf_wb_data_o  out  XLEN; l1d_int_prf_wb_vld_from_mlfb_o  out  1.
REQ-008 SHALL have hit_stall_o  out  1: stall request to the load issue stage.

Function
REQ-009 SHALL accept a refill on refill_vld_i & refill_rdy_o into a FIFO, with refill_rdy_o = (count < REFILL_FIFO_DEPTH) & ~flush_i.
REQ-010 SHALL drive the writeback from hit inputs in the same cycle whenever hit_vld_i=1, with zero latency, in either state.
REQ-011 SHALL drive the writeback from the FIFO head and pop it when hit_vld_i=0 and the FIFO is non-empty. l1d_int_prf_wb_vld_from_mlfb_o SHALL be 1 only in that case.
REQ-012 SHALL expose a pushed entry no earlier than the cycle after the push, with no same-cycle bypass, including when the FIFO is empty.
REQ-013 SHALL allow push and pop in the same cycle when not full, with count unchanged. Pointers SHALL wrap modulo REFILL_FIFO_DEPTH.
REQ-014 SHALL keep l1d_int_prf_wb_vld_o equal to l1d_rob_wb_vld_o. The tag and data outputs SHALL be 0 when valid is 0.
REQ-015 SHALL implement the FSM states HIT_PRI and DRAIN.
REQ-016 In HIT_PRI, the starve counter SHALL increment on each cycle where the FIFO is non-empty and hit_vld_i=1. It SHALL clear on any pop or when the FIFO is empty.
REQ-017 SHALL move HIT_PRI to DRAIN when the starve counter reaches STARVE_LIMIT, then clear the counter.
REQ-018 In DRAIN, SHALL hold hit_stall_o=1. In-flight hits SHALL still win the port. SHALL return to HIT_PRI the cycle after the FIFO becomes empty.
REQ-019 SHALL assert hit_stall_o in HIT_PRI whenever count >= REFILL_FIFO_DEPTH-2. hit_stall_o SHALL be combinational from registered state and count only.
REQ-020 On flush_i=1, SHALL drop all FIFO entries and drop any refill offered that cycle. The next cycle SHALL show count=0, counter=0, state=HIT_PRI. A hit writeback in the flush cycle SHALL still be driven.
REQ-021 SHALL never lose or duplicate a refill entry and SHALL preserve FIFO order.

Reset
REQ-022 On rst=1 at a clock edge, count, pointers and the starve counter SHALL be 0, and the state SHALL be HIT_PRI.
REQ-023 While rst=1, all valid outputs SHALL be 0 and refill_rdy_o SHALL be 0. Entries in flight are discarded and rst SHALL override flush_i.
REQ-024 Storage data is not reset. Only valid, count and pointer state is reset.

Verification
REQ-025 Single refill rob_tag=5, data=0xDEAD, no hits -> writeback vld with from_mlfb=1 and tag 5 exactly one cycle after acceptance.
REQ-026 Hit and FIFO head valid in the same cycle -> hit written back, head retained. On the next idle cycle -> head written back.
REQ-027 Four refills pushed in back-to-back cycles while hits are continuous -> refill_rdy_o=0 at count=4, hit_stall_o=1 from count=2, zero entries lost.
REQ-028 One buffered refill with hits continuous for 8 cycles -> state DRAIN, hit_stall_o=1. When hits stop, refill written back and HIT_PRI the following cycle.
REQ-029 Three entries buffered, flush_i pulsed together with a hit and a refill offer -> hit written back that cycle, next cycle count=0, no refill writebacks.
REQ-030 rst asserted while in DRAIN with FIFO non-empty -> next cycle all outputs 0 and HIT_PRI. After reset release, refill_rdy_o=1.
